// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, default width, state encoding
// and the opcode-to-slice-control decode.
package alu_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       a_inv;
    logic       b_inv;
    logic       cin;
    logic [1:0] op;
  } ctrl_t;

  function automatic ctrl_t alu_decode(input logic [3:0] code);
    ctrl_t c;
    c = '0;
    case (code)
      OpAnd:   c = '{valid: 1'b1, a_inv: 1'b0, b_inv: 1'b0, cin: 1'b0, op: 2'b00};
      OpOr:    c = '{valid: 1'b1, a_inv: 1'b0, b_inv: 1'b0, cin: 1'b0, op: 2'b01};
      OpAdd:   c = '{valid: 1'b1, a_inv: 1'b0, b_inv: 1'b0, cin: 1'b0, op: 2'b10};
      OpSub:   c = '{valid: 1'b1, a_inv: 1'b0, b_inv: 1'b1, cin: 1'b1, op: 2'b10};
      OpSlt:   c = '{valid: 1'b1, a_inv: 1'b0, b_inv: 1'b1, cin: 1'b1, op: 2'b11};
      OpNor:   c = '{valid: 1'b1, a_inv: 1'b1, b_inv: 1'b1, cin: 1'b0, op: 2'b00};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_top.sv
// 1-bit ALU slice: optional operand inversion, AND/OR/sum/less select, full-adder carry.
module alu_top (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       less_i,
  input  logic       a_invert_i,
  input  logic       b_invert_i,
  input  logic       cin_i,
  input  logic [1:0] operation_i,
  output logic       result_o,
  output logic       cout_o
);

  logic a_p, b_p;

  always_comb begin
    a_p    = a_i ^ a_invert_i;
    b_p    = b_i ^ b_invert_i;
    cout_o = (a_p & b_p) | (a_p & cin_i) | (b_p & cin_i);
    unique case (operation_i)
      2'b00:   result_o = a_p & b_p;
      2'b01:   result_o = a_p | b_p;
      2'b10:   result_o = a_p ^ b_p ^ cin_i;
      default: result_o = less_i;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: feeds one operand bit per cycle through a single alu_top slice,
// LSB first, and applies the overflow / SLT fix-up on the MSB cycle.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  ctrl_t            ctrl_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_q, cout_q, ovf_q;

  logic accept, last_bit;
  logic slice_result, slice_cout;
  logic msb_ovf, slt_set;
  ctrl_t start_ctrl;

  assign start_ctrl = alu_decode(ALU_control_i);
  assign accept     = (state_q == StIdle) && start_i;
  assign last_bit   = (idx_q == IdxW'(WIDTH - 1));

  alu_top u_slice (
    .a_i         (a_q[idx_q]),
    .b_i         (b_q[idx_q]),
    .less_i      (1'b0),
    .a_invert_i  (ctrl_q.a_inv),
    .b_invert_i  (ctrl_q.b_inv),
    .cin_i       (carry_q),
    .operation_i (ctrl_q.op),
    .result_o    (slice_result),
    .cout_o      (slice_cout)
  );

  // On the MSB cycle carry_q is the carry into the MSB.
  assign msb_ovf = carry_q ^ slice_cout;
  assign slt_set = (a_q[idx_q] ^ ctrl_q.a_inv) ^ (b_q[idx_q] ^ ctrl_q.b_inv) ^ carry_q ^ msb_ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (last_bit) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q      <= src1_i;
      b_q      <= src2_i;
      ctrl_q   <= start_ctrl;
      idx_q    <= '0;
      carry_q  <= start_ctrl.cin;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state_q == StRun) begin
      result_q[idx_q] <= ctrl_q.valid & slice_result;
      carry_q         <= slice_cout;
      if (!last_bit) begin
        idx_q <= idx_q + 1'b1;
      end else if (ctrl_q.valid) begin
        if (ctrl_q.op[1]) cout_q <= slice_cout;
        if (ctrl_q.op == 2'b10) ovf_q <= msb_ovf;
        // SLT: the slice wrote 0 everywhere; the sign-corrected compare lands in bit 0.
        if (ctrl_q.op == 2'b11) result_q[0] <= slt_set;
      end
    end
  end

  always_comb begin
    busy_o     = (state_q == StRun) || (state_q == StFin);
    done_o     = (state_q == StFin);
    result_o   = result_q;
    zero_o     = done_o && (result_q == '0);
    cout_o     = cout_q;
    overflow_o = ovf_q;
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq with hand-computed expectations.
module tb_alu_serial_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] src1 = '0, src2 = '0;
  logic [3:0]   alu_ctrl = 4'b0000;
  logic [W-1:0] result;
  logic         zero, cout, overflow, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int seen;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .src1_i        (src1),
    .src2_i        (src2),
    .ALU_control_i (alu_ctrl),
    .result_o      (result),
    .zero_o        (zero),
    .cout_o        (cout),
    .overflow_o    (overflow),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op; returns edges from acceptance to done (or 100 on timeout).
  // glitch_at >= 0 pulses start with different operands at that cycle.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int glitch_at, output int l);
    @(negedge clk);
    start = 1'b1; alu_ctrl = op; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    while (!done && l < 100) begin
      if (l == glitch_at) begin
        start = 1'b1; alu_ctrl = 4'b0110; src1 = 32'd100; src2 = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      l++;
    end
    start = 1'b0;
    if (l >= 100) check("done_timeout", 64'(l), 64'd32);
  endtask

  // After a done cycle: next cycle must be IDLE with done low.
  task automatic check_after_done(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", {59'd0, zero, cout, overflow, busy, done}, 64'd0);
    rst = 1'b0;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, -1, lat);
    check("add_ovf_latency", 64'(lat), 64'd32);
    check("add_ovf_result", 64'(result), 64'h8000_0000);
    check("add_ovf_flags", {60'd0, zero, cout, overflow, busy}, {60'd0, 4'b0011});
    check_after_done("add_ovf");

    run_op(4'b0110, 32'd5, 32'd5, -1, lat);
    check("sub_eq_result", 64'(result), 64'd0);
    check("sub_eq_flags", {61'd0, zero, cout, overflow}, {61'd0, 3'b110});
    check_after_done("sub_eq");

    run_op(4'b0111, 32'h8000_0000, 32'h0000_0001, -1, lat);
    check("slt_neg_result", 64'(result), 64'd1);
    check("slt_neg_flags", {62'd0, cout, overflow}, {62'd0, 2'b10});
    check_after_done("slt_neg");
    // Back-to-back: this start lands in the first IDLE cycle.
    run_op(4'b0111, 32'd5, 32'd3, -1, lat);
    check("slt_b2b_latency", 64'(lat), 64'd32);
    check("slt_pos_result", 64'(result), 64'd0);
    check("slt_pos_flags", {61'd0, zero, cout, overflow}, {61'd0, 3'b110});
    check_after_done("slt_pos");

    run_op(4'b1100, 32'd0, 32'd0, -1, lat);
    check("nor_result", 64'(result), 64'hFFFF_FFFF);
    check("nor_flags", {61'd0, zero, cout, overflow}, 64'd0);
    check_after_done("nor");

    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, -1, lat);
    check("and_result", 64'(result), 64'hF000_F000);
    check("and_flags", {62'd0, cout, overflow}, 64'd0);
    check_after_done("and");

    run_op(4'b0001, 32'h0F0F_0000, 32'h0000_F0F0, -1, lat);
    check("or_result", 64'(result), 64'h0F0F_F0F0);
    check_after_done("or");

    run_op(4'b0110, 32'd3, 32'd5, -1, lat);
    check("sub_neg_result", 64'(result), 64'hFFFF_FFFE);
    check("sub_neg_flags", {61'd0, zero, cout, overflow}, 64'd0);
    check_after_done("sub_neg");

    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, -1, lat);
    check("add_wrap_result", 64'(result), 64'd0);
    check("add_wrap_flags", {61'd0, zero, cout, overflow}, {61'd0, 3'b110});
    check_after_done("add_wrap");

    run_op(4'b1111, 32'd5, 32'd3, -1, lat);
    check("bad_op_latency", 64'(lat), 64'd32);
    check("bad_op_result", 64'(result), 64'd0);
    check("bad_op_flags", {61'd0, zero, cout, overflow}, {61'd0, 3'b100});
    check_after_done("bad_op");

    // Start pulsed mid-run must be ignored.
    run_op(4'b0010, 32'd1, 32'd2, 5, lat);
    check("busy_ign_latency", 64'(lat), 64'd32);
    check("busy_ign_result", 64'(result), 64'd3);
    // Start raised during the done cycle must also be ignored.
    start = 1'b1; alu_ctrl = 4'b0010; src1 = 32'd7; src2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("fin_start_ign_busy", 64'(busy), 64'd0);
    check("fin_start_ign_result", 64'(result), 64'd3);

    // Reset while bit 10 is in flight.
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'b0010; src1 = 32'h1234_5678; src2 = 32'h1111_1111;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("partial_low_bits", 64'(result[9:0]), 64'h389);
    check("partial_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_result", 64'(result), 64'd0);
    check("abort_flags", {59'd0, zero, cout, overflow, busy, done}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named clk_i and rst_i.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand and result width in bits.
REQ-003 clk_i  in  1  rising-edge clock.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 start_i  in  1  request; sampled only in IDLE.
REQ-006 src1_i  in  WIDTH  operand A, latched on an accepted start.
REQ-007 src2_i  in  WIDTH  operand B, latched on an accepted start.
REQ-008 ALU_control_i  in  4  operation code, latched on an accepted start.
REQ-009 result_o  out  WIDTH  registered result, held until the next accepted start.
REQ-010 zero_o  out  1  high when result_o == 0, valid while done_o is high.
REQ-011 cout_o  out  1  final carry for ADD/SUB/SLT; 0 for logic operations.
REQ-012 overflow_o  out  1  signed overflow for ADD/SUB; 0 for all other operations.
REQ-013 busy_o  out  1  high in RUN and FIN.
REQ-014 done_o  out  1  one-cycle pulse in FIN.

Function
REQ-015 The block SHALL have three states: IDLE, RUN and FIN.
REQ-016 State transitions SHALL be: IDLE->RUN on start_i; RUN->FIN after bit WIDTH-1; FIN->IDLE unconditionally.
REQ-017 An accepted start SHALL latch the operands and opcode, clear the bit index to 0, clear result_o, and load the carry register with cin.
REQ-018 cin SHALL be 1 for SUB and SLT, and 0 otherwise.
REQ-019 Opcode decode to {A_invert, B_invert, operation} SHALL be:
  - AND 0000 -> 0,0,00
  - OR 0001 -> 0,0,01
  - ADD 0010 -> 0,0,10
  - SUB 0110 -> 0,1,10
  - SLT 0111 -> 0,1,11
  - NOR 1100 -> 1,1,00
REQ-020 Any other opcode SHALL run the full sequence and produce result 0, cout_o 0 and overflow_o 0.
REQ-021 In RUN, each cycle SHALL process one bit, LSB first: it drives bit[idx] of A and B into the 1-bit slice, writes the slice result into result_o[idx], loads the slice cout into the carry register, and increments idx.
REQ-022 The slice less input SHALL be 0 for every bit.
REQ-023 At bit WIDTH-1, overflow SHALL be computed as carry_in_msb XOR carry_out_msb.
REQ-024 For SLT, at bit WIDTH-1 the block SHALL compute set = a' XOR b' XOR carry_in_msb XOR overflow and write set into result_o[0]; here a' and b' are the inverted MSB operands.
REQ-025 Latency SHALL be fixed: a start accepted at edge k gives done_o high in the cycle after edge k+WIDTH (WIDTH+1 cycles from start to done).
REQ-026 start_i SHALL be ignored while busy_o is high; a start in the same cycle that done_o is high SHALL be ignored.
REQ-027 Back-to-back operation SHALL be possible: start_i high in the first IDLE cycle after FIN SHALL be accepted.
REQ-028 The idx counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap into a second pass.
REQ-029 All outputs SHALL be registered or derived from registered state only.

Reset
REQ-030 rst_i, synchronous and dominant over start_i, SHALL force state IDLE, idx 0, carry 0, and all outputs 0 (result_o, zero_o, cout_o, overflow_o, busy_o, done_o).
REQ-031 A reset asserted mid-RUN SHALL abort the operation with no done_o pulse, and the partial result SHALL be discarded (result_o = 0).

Structure
REQ-032 A shared package alu_pkg SHALL hold the opcode localparams (AND, OR, ADD, SUB, SLT, NOR), the default WIDTH and the state encoding.
REQ-033 The block SHALL instantiate exactly one existing 1-bit slice, alu_top; the carry register, sequencing and SLT/overflow fix-up SHALL sit in alu_serial_seq.

Verification
REQ-034 ADD, 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, done at cycle 33.
REQ-035 SUB, 5 - 5 -> result 0, zero 1, cout 1, overflow 0.
REQ-036 SLT, A=0x80000000, B=0x00000001 -> result 1; then A=5, B=3 -> result 0, issued back-to-back per REQ-027.
REQ-037 NOR, A=0, B=0 -> result 0xFFFFFFFF, cout 0, overflow 0; AND, A=0xF0F0F0F0, B=0xFF00FF00 -> result 0xF000F000.
REQ-038 Start accepted, then start_i pulsed while busy_o is high -> ignored, and the original result completes unchanged.
REQ-039 rst_i asserted at bit 10 of an ADD -> next cycle IDLE with all outputs 0, and no done_o pulse follows.
